hex_neighbor_fetch: RTL and testbench
=====================================

HEX_NEIGHBOR_FETCH -- requirements
Module: hex_neighbor_fetch

Interface
REQ-001 Parameter GRID_W, default 16, grid columns; power of two, 2..256.
REQ-002 Parameter GRID_H, default 16, grid rows; 2..256.
REQ-003 Parameter AW, default log2(GRID_W*GRID_H), RAM address width.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a full-grid sweep; ignored while busy=1.
REQ-007 beta  in  18  signed 2.16 boundary value, substituted for out-of-grid neighbours.
REQ-008 rd_en  out  1  RAM read strobe.
REQ-009 rd_addr  out  AW  RAM read address, equal to row*GRID_W + col.
REQ-010 rd_data  in  18  signed 2.16 u value, valid exactly one cycle after an rd_en cycle.
REQ-011 u_curr, u_neighbor_0..u_neighbor_5  out  18 each  signed 2.16 centre and neighbour u values for the diffusion solver.
REQ-012 cell_addr  out  AW  address of the centre cell currently presented.
REQ-013 out_valid  out  1  window outputs valid.
REQ-014 out_ready  in  1  consumer accepts the window.
REQ-015 busy  out  1  high from the cycle after start until done.
REQ-016 done  out  1  one-cycle pulse after the last cell's window is accepted.

Function
REQ-017 Neighbour geometry, for centre (r,c): n0=(r-1,c), n1=(r-1,c+1), n2=(r,c-1), n3=(r,c+1), n4=(r+1,c-1), n5=(r+1,c).
REQ-018 Cells are visited in raster order: r=0..GRID_H-1 outer, c=0..GRID_W-1 inner.
REQ-019 States: IDLE, FETCH, WAIT, PRESENT, DONE.
REQ-020 IDLE: on start=1, move to FETCH with r=c=0 and busy=1.
REQ-021 FETCH lasts exactly 7 cycles, slot k=0..6, with slot 0 = centre and slots 1..6 = n0..n5.
REQ-022 In-grid slot: rd_en=1 and rd_addr = that cell's address.
REQ-023 Out-of-grid slot (row or col <0 or >=limit): rd_en=0, and the corresponding output register is loaded with beta; no wrap-around.
REQ-024 Data returned in cycle k+1 is captured into the register for slot k.
REQ-025 WAIT: one cycle that captures slot 6 data.
REQ-026 PRESENT: out_valid=1, and all window outputs and cell_addr are held stable until out_ready=1.
REQ-027 out_ready=1 in the first PRESENT cycle is legal, giving zero stall.
REQ-028 Latency: out_valid rises 8 cycles after FETCH entry; minimum period is 9 cycles per cell.
REQ-029 On accept of a non-last cell: advance c, wrapping to c=0 with r+1 at c=GRID_W-1, and enter FETCH the next cycle.
REQ-030 On accept of the last cell (r=GRID_H-1, c=GRID_W-1): enter DONE.
REQ-031 DONE: done=1 and busy=0 for one cycle, then IDLE.
REQ-032 start asserted in any non-IDLE state has no effect.
REQ-033 Data is passed through bit-exact; no arithmetic is applied to u values.
REQ-034 rd_en shall be 0 in IDLE, WAIT, PRESENT and DONE.

Reset
REQ-035 Reset in any state, including mid-FETCH or PRESENT, forces IDLE within the same clock.
REQ-036 Reset values: rd_en=0, out_valid=0, busy=0, done=0, rd_addr=0, cell_addr=0, r=c=0, all window registers=0.
REQ-037 rd_data returned after reset is discarded.
REQ-038 A start pulse coincident with reset is ignored.

Verification
REQ-039 Corner cell: RAM[a]=a<<4, beta=0x04000, GRID 16x16, start; first window (0,0) -> u_curr=0x00000, n0=n1=n2=n4=0x04000, n3=0x00010, n5=0x00100.
REQ-040 Interior cell (5,7): window equals RAM at addresses 71/72/86/88/102/103 for n0..n5, cell_addr=87, and rd_en is low on no slot.
REQ-041 Backpressure: out_ready held 0 for 20 cycles on cell 3 -> outputs stable and rd_en=0 throughout; accept -> cell 4 out_valid exactly 9 cycles later.
REQ-042 Full sweep with out_ready=1: exactly 256 accepts, raster-ordered cell_addr 0..255, done pulses once 2304 cycles (256x9) after FETCH entry, then busy=0.
REQ-043 Reset mid-sweep at slot 3 of cell 40 -> next cycle all outputs at reset values; a later start restarts at cell 0.
REQ-044 A start pulse during PRESENT -> no effect: no extra sweep, and the done count stays 1.

Source files
------------

// File: rtl/hex_neighbor_fetch_if.sv
// Bundle for hex_neighbor_fetch: start/boundary control, RAM read port and
// the window output handshake. Signal prefixes are from the fetch block's
// point of view (i_ = into the block, o_ = out of the block).
// All u values and beta are signed 2.16. They travel as raw 18-bit words
// because the block never does arithmetic on them.
interface hex_neighbor_fetch_if #(
   parameter int AW = 8
) ();
   logic          i_start;
   logic [17:0]   i_beta;
   logic          o_rd_en;
   logic [AW-1:0] o_rd_addr;
   logic [17:0]   i_rd_data;
   logic [17:0]   o_u_curr;
   logic [17:0]   o_u_neighbor_0;
   logic [17:0]   o_u_neighbor_1;
   logic [17:0]   o_u_neighbor_2;
   logic [17:0]   o_u_neighbor_3;
   logic [17:0]   o_u_neighbor_4;
   logic [17:0]   o_u_neighbor_5;
   logic [AW-1:0] o_cell_addr;
   logic          o_out_valid;
   logic          i_out_ready;
   logic          o_busy;
   logic          o_done;

   // Fetch block side.
   modport slave (
      input  i_start, i_beta, i_rd_data, i_out_ready,
      output o_rd_en, o_rd_addr, o_u_curr,
             o_u_neighbor_0, o_u_neighbor_1, o_u_neighbor_2,
             o_u_neighbor_3, o_u_neighbor_4, o_u_neighbor_5,
             o_cell_addr, o_out_valid, o_busy, o_done
   );

   // Controller / RAM / consumer side.
   modport master (
      output i_start, i_beta, i_rd_data, i_out_ready,
      input  o_rd_en, o_rd_addr, o_u_curr,
             o_u_neighbor_0, o_u_neighbor_1, o_u_neighbor_2,
             o_u_neighbor_3, o_u_neighbor_4, o_u_neighbor_5,
             o_cell_addr, o_out_valid, o_busy, o_done
   );
endinterface

// File: rtl/hex_neighbor_fetch.sv
// hex_neighbor_fetch: sweeps a GRID_H x GRID_W hex grid in raster order.
// For every cell it reads the centre and its six hex neighbours from a RAM
// with one cycle of read latency. It substitutes beta for neighbours that
// fall off the grid, then presents the 7-value window to the diffusion
// solver with a valid/ready handshake.
module hex_neighbor_fetch #(
   parameter int GRID_W = 16,
   parameter int GRID_H = 16,
   parameter int AW     = $clog2(GRID_W * GRID_H)
) (
   input  logic                clk,
   input  logic                reset,
   hex_neighbor_fetch_if.slave bus
);

   localparam int CW = $clog2(GRID_W);
   localparam int RW = $clog2(GRID_H);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_WAIT    = 3'd2,
      S_PRESENT = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t          r_state;
   logic [RW-1:0]   r_row;
   logic [CW-1:0]   r_col;
   logic [2:0]      r_slot;
   logic            r_rd_en;
   logic [AW-1:0]   r_rd_addr;
   logic [AW-1:0]   r_cell_addr;
   logic            r_out_valid;
   logic            r_busy;
   logic            r_done;

   // Read-return pipeline: describes the read issued in the previous cycle.
   logic            r_cap_en;
   logic            r_cap_inb;
   logic [2:0]      r_cap_slot;
   logic [17:0]     r_win [0:6];

   logic            w_last_col;
   logic            w_last_row;
   logic            w_last_cell;
   logic [RW-1:0]   w_next_row;
   logic [CW-1:0]   w_next_col;
   logic [AW-1:0]   w_next_addr;
   logic [AW:0]     w_lookup;

   // Slot -> {in_grid, address}. Slot 0 is the centre; slots 1..6 are n0..n5
   // at offsets (-1,0) (-1,+1) (0,-1) (0,+1) (+1,-1) (+1,0). The grid does
   // not wrap, so an off-grid neighbour reports in_grid = 0.
   function automatic logic [AW:0] slot_lookup(input int row, input int col,
                                               input logic [2:0] slot);
      int v_r;
      int v_c;
      v_r = row;
      v_c = col;
      case (slot)
         3'd1:    begin v_r = row - 32'sd1; v_c = col;          end
         3'd2:    begin v_r = row - 32'sd1; v_c = col + 32'sd1; end
         3'd3:    begin v_r = row;          v_c = col - 32'sd1; end
         3'd4:    begin v_r = row;          v_c = col + 32'sd1; end
         3'd5:    begin v_r = row + 32'sd1; v_c = col - 32'sd1; end
         3'd6:    begin v_r = row + 32'sd1; v_c = col;          end
         default: begin v_r = row;          v_c = col;          end
      endcase
      if ((v_r >= 32'sd0) && (v_r < GRID_H) && (v_c >= 32'sd0) && (v_c < GRID_W)) begin
         slot_lookup = {1'b1, AW'(v_r * GRID_W + v_c)};
      end else begin
         slot_lookup = {1'b0, {AW{1'b0}}};
      end
   endfunction

   // Next raster position and the addressing of the slot after the current one.
   always_comb begin
      w_lookup   = slot_lookup(int'(r_row), int'(r_col), r_slot + 3'd1);
      w_last_col = (r_col == CW'(GRID_W - 1));
      w_last_row = (r_row == RW'(GRID_H - 1));
      w_last_cell = w_last_col && w_last_row;
      if (w_last_col) begin
         w_next_col = {CW{1'b0}};
         w_next_row = r_row + RW'(1);
      end else begin
         w_next_col = r_col + CW'(1);
         w_next_row = r_row;
      end
      w_next_addr = AW'(int'(w_next_row) * GRID_W + int'(w_next_col));
   end

   // Sweep controller. rd_en/rd_addr are registered, so each transition into
   // FETCH already sets up the centre read for slot 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_row       <= {RW{1'b0}};
         r_col       <= {CW{1'b0}};
         r_slot      <= 3'd0;
         r_rd_en     <= 1'b0;
         r_rd_addr   <= {AW{1'b0}};
         r_cell_addr <= {AW{1'b0}};
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_out_valid <= 1'b0;
               r_done      <= 1'b0;
               if (bus.i_start) begin
                  r_state     <= S_FETCH;
                  r_row       <= {RW{1'b0}};
                  r_col       <= {CW{1'b0}};
                  r_slot      <= 3'd0;
                  r_rd_en     <= 1'b1;
                  r_rd_addr   <= {AW{1'b0}};
                  r_cell_addr <= {AW{1'b0}};
                  r_busy      <= 1'b1;
               end else begin
                  r_rd_en <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end
            S_FETCH: begin
               if (r_slot == 3'd6) begin
                  r_state <= S_WAIT;
                  r_rd_en <= 1'b0;
               end else begin
                  r_slot    <= r_slot + 3'd1;
                  r_rd_en   <= w_lookup[AW];
                  r_rd_addr <= w_lookup[AW-1:0];
               end
            end
            S_WAIT: begin
               // Slot 6 data lands this cycle; the window is complete next cycle.
               r_state     <= S_PRESENT;
               r_out_valid <= 1'b1;
            end
            S_PRESENT: begin
               if (bus.i_out_ready) begin
                  r_out_valid <= 1'b0;
                  if (w_last_cell) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state     <= S_FETCH;
                     r_row       <= w_next_row;
                     r_col       <= w_next_col;
                     r_slot      <= 3'd0;
                     r_rd_en     <= 1'b1;
                     r_rd_addr   <= w_next_addr;
                     r_cell_addr <= w_next_addr;
                  end
               end else begin
                  r_out_valid <= 1'b1;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state     <= S_IDLE;
               r_rd_en     <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   // Capture returning read data (or beta for off-grid slots) into the window
   // register of the slot that issued the read one cycle earlier.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cap_en   <= 1'b0;
         r_cap_inb  <= 1'b0;
         r_cap_slot <= 3'd0;
         for (int i = 0; i < 7; i++) begin
            r_win[i] <= 18'd0;
         end
      end else begin
         r_cap_en   <= (r_state == S_FETCH);
         r_cap_inb  <= r_rd_en;
         r_cap_slot <= r_slot;
         if (r_cap_en) begin
            if (r_cap_inb) begin
               r_win[r_cap_slot] <= bus.i_rd_data;
            end else begin
               r_win[r_cap_slot] <= bus.i_beta;
            end
         end
      end
   end

   assign bus.o_rd_en        = r_rd_en;
   assign bus.o_rd_addr      = r_rd_addr;
   assign bus.o_cell_addr    = r_cell_addr;
   assign bus.o_out_valid    = r_out_valid;
   assign bus.o_busy         = r_busy;
   assign bus.o_done         = r_done;
   assign bus.o_u_curr       = r_win[0];
   assign bus.o_u_neighbor_0 = r_win[1];
   assign bus.o_u_neighbor_1 = r_win[2];
   assign bus.o_u_neighbor_2 = r_win[3];
   assign bus.o_u_neighbor_3 = r_win[4];
   assign bus.o_u_neighbor_4 = r_win[5];
   assign bus.o_u_neighbor_5 = r_win[6];

endmodule

// File: tb/tb_hex_neighbor_fetch.sv
// Self-checking bench for hex_neighbor_fetch on a 16x16 grid. The reference
// model derives each window straight from the hex geometry over a RAM image.
module tb_hex_neighbor_fetch;
   localparam int GW = 16;
   localparam int GH = 16;
   localparam int AW = 8;
   localparam int NC = GW * GH;

   logic clk = 1'b0;
   logic reset;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_done = 0;

   logic [17:0]  mem [0:NC-1];
   logic [17:0]  beta_v;
   logic [125:0] win_seen [0:NC-1];
   int           stall_tab [0:NC-1];
   int           pulse_cell;
   int           t_fetch;
   int           t_accept;
   int           t_expect_valid;
   int           total_stall;

   hex_neighbor_fetch_if #(.AW(AW)) bus ();

   hex_neighbor_fetch #(.GRID_W(GW), .GRID_H(GH), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (bus.o_done === 1'b1) n_done <= n_done + 1;

   // RAM model with one cycle of read latency; garbage when not reading.
   always @(posedge clk) begin
      if (bus.o_rd_en === 1'b1) bus.i_rd_data <= mem[bus.o_rd_addr];
      else                      bus.i_rd_data <= 18'($urandom);
   end

   assign bus.i_beta = beta_v;

   wire [125:0] w_win = {bus.o_u_curr, bus.o_u_neighbor_0, bus.o_u_neighbor_1,
                         bus.o_u_neighbor_2, bus.o_u_neighbor_3,
                         bus.o_u_neighbor_4, bus.o_u_neighbor_5};
   wire [145:0] w_all = {bus.o_rd_en, bus.o_out_valid, bus.o_busy, bus.o_done,
                         bus.o_rd_addr, bus.o_cell_addr, w_win};

   function automatic logic [17:0] ref_u(input int r, input int c);
      if (r < 0 || r >= GH || c < 0 || c >= GW) return beta_v;
      return mem[r * GW + c];
   endfunction

   function automatic logic [125:0] ref_win(input int idx);
      int r;
      int c;
      r = idx / GW;
      c = idx % GW;
      return {ref_u(r, c), ref_u(r - 1, c), ref_u(r - 1, c + 1), ref_u(r, c - 1),
              ref_u(r, c + 1), ref_u(r + 1, c - 1), ref_u(r + 1, c)};
   endfunction

   function automatic int ref_reads(input int idx);
      int dr [7] = '{0, -1, -1, 0, 0, 1, 1};
      int dc [7] = '{0, 0, 1, -1, 1, -1, 0};
      int n;
      int r;
      int c;
      n = 0;
      for (int k = 0; k < 7; k++) begin
         r = idx / GW + dr[k];
         c = idx % GW + dc[k];
         if (r >= 0 && r < GH && c >= 0 && c < GW) n++;
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_sweep();
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      t_fetch = cyc;
      t_expect_valid = t_fetch + 8;
      total_stall = 0;
      chk("fetch_entry", {bus.o_busy, bus.o_rd_en, bus.o_rd_addr}, {1'b1, 1'b1, 8'h00});
   endtask

   // Called at the negedge of the first FETCH cycle of cell idx; returns at
   // the negedge of the cycle after the accept.
   task automatic serve_cell(input int idx, input int stall, input bit do_pulse);
      int reads;
      bit seen;
      bit bad;
      logic [125:0] snap;
      reads = 0;
      seen = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bus.o_out_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (bus.o_rd_en === 1'b1) reads++;
         @(negedge clk);
      end
      chk("valid_seen", seen, 1'b1);
      if (seen) begin
         chk("latency", cyc, t_expect_valid);
         chk("cell_addr", bus.o_cell_addr, idx[7:0]);
         chk("window", w_win, ref_win(idx));
         chk("reads", reads, ref_reads(idx));
         chk("present_rd_en", bus.o_rd_en, 1'b0);
         win_seen[idx] = w_win;
         snap = w_win;
         bus.i_out_ready = 1'b0;
         if (do_pulse) bus.i_start = 1'b1;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            if (bus.o_out_valid !== 1'b1 || bus.o_rd_en !== 1'b0 || w_win !== snap ||
                bus.o_cell_addr !== idx[7:0]) bad = 1'b1;
         end
         bus.i_start = 1'b0;
         if (stall > 0) chk("stall_stable", bad, 1'b0);
         bus.i_out_ready = 1'b1;
         t_accept = cyc;
         total_stall += stall;
         t_expect_valid = t_accept + 9;
         @(negedge clk);
         bus.i_out_ready = 1'b0;
      end
   endtask

   task automatic run_sweep(input bit check_idle_after);
      int done_before;
      done_before = n_done;
      start_sweep();
      for (int i = 0; i < NC; i++) serve_cell(i, stall_tab[i], i == pulse_cell);
      chk("done_pulse", {bus.o_done, bus.o_busy, bus.o_out_valid}, 3'b100);
      chk("done_time", cyc - t_fetch, 2304 + total_stall);
      @(negedge clk);
      chk("done_clear", {bus.o_done, bus.o_busy, bus.o_out_valid}, 3'b000);
      chk("done_count", n_done - done_before, 1);
      if (check_idle_after) begin
         repeat (30) @(negedge clk);
         chk("no_extra_sweep", {bus.o_busy, bus.o_out_valid, bus.o_rd_en}, 3'b000);
         chk("done_count_final", n_done - done_before, 1);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.i_start = 1'b1;          // start coincident with reset must be ignored
      bus.i_out_ready = 1'b0;
      beta_v = 18'h04000;
      pulse_cell = -1;
      for (int a = 0; a < NC; a++) begin
         mem[a] = 18'(a << 4);
         stall_tab[a] = 0;
      end
      repeat (3) @(negedge clk);
      chk("reset_state", w_all, 160'd0);
      reset = 1'b0;
      bus.i_start = 1'b0;
      @(negedge clk);
      chk("start_with_reset", w_all, 160'd0);

      // Sweep 1: address-pattern RAM, zero stall everywhere.
      run_sweep(1'b0);
      chk("corner_00", win_seen[0],
          {18'h00000, 18'h04000, 18'h04000, 18'h04000, 18'h00010, 18'h04000, 18'h00100});
      chk("interior_87", win_seen[87],
          {18'h00570, 18'h00470, 18'h00480, 18'h00560, 18'h00580, 18'h00660, 18'h00670});

      // Sweep 2: random RAM and beta, random stalls, long stall on cell 3,
      // start pulse while cell 10 is presented.
      for (int a = 0; a < NC; a++) begin
         mem[a] = 18'($urandom);
         stall_tab[a] = $urandom_range(0, 2);
      end
      beta_v = 18'($urandom);
      stall_tab[3] = 20;
      stall_tab[10] = 3;
      pulse_cell = 10;
      run_sweep(1'b1);

      // Reset at slot 3 of cell 40, then a fresh sweep from cell 0.
      for (int a = 0; a < NC; a++) begin
         mem[a] = 18'($urandom);
         stall_tab[a] = 0;
      end
      beta_v = 18'($urandom);
      pulse_cell = -1;
      start_sweep();
      for (int i = 0; i < 40; i++) serve_cell(i, 0, 1'b0);
      repeat (3) @(negedge clk);
      chk("slot3_rd", {bus.o_rd_en, bus.o_rd_addr}, {1'b1, 8'd39});
      reset = 1'b1;
      @(negedge clk);
      chk("reset_mid", w_all, 160'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_after_reset", w_all, 160'd0);
      run_sweep(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
